// File: rtl/exe_stage.sv
// exe_stage -- execute stage of the 5-stage ARM pipeline.
//   Forwarding muxes select each operand from the ID value, the MEM result or the WB result.
//   The Val2 generator then forms the second operand for the ALU.
//   The stage also holds the ALU, the branch-target adder and the NZCV status register.
//   The EXE/MEM pipeline register closes the stage.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   *_in                               ID/EXE register fields (controls, opcode, operands, shifter, dest, NZCV)
//   sel_src1/sel_src2, *_fwd_val       forwarding selects and forwarded values
//   branch_taken, branch_addr, status  combinational/architectural feedback to IF/ID
//   wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest   registered EXE/MEM outputs
module exe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [3:0]        sr_in,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] val_rm,
  output logic [REG_AW-1:0] dest
);

  logic [DATA_W-1:0]   w_op1, w_rm, w_val2, w_immv, w_shf, w_b, w_res;
  logic [2*DATA_W-1:0] w_imm_rr, w_rm_rr;
  logic [DATA_W:0]     w_sum;
  logic [4:0]          w_amt, w_rot;
  logic                w_ci, w_arith, w_n, w_z, w_c, w_v;

  logic [3:0]          r_status;
  logic                r_wb_en, r_mem_r_en, r_mem_w_en;
  logic [DATA_W-1:0]   r_alu_res, r_val_rm;
  logic [REG_AW-1:0]   r_dest;

  // Forwarding: code 11 is unused and falls back to the ID value.
  always_comb begin
    case (sel_src1)
      2'b01:   w_op1 = mem_fwd_val;
      2'b10:   w_op1 = wb_fwd_val;
      default: w_op1 = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   w_rm = mem_fwd_val;
      2'b10:   w_rm = wb_fwd_val;
      default: w_rm = val_rm_in;
    endcase
  end

  // Rotations are done by shifting a doubled word right and keeping the low half.
  assign w_rot    = {shift_operand_in[11:8], 1'b0};
  assign w_immv   = {{(DATA_W-8){1'b0}}, shift_operand_in[7:0]};
  assign w_imm_rr = {w_immv, w_immv} >> w_rot;
  assign w_amt    = shift_operand_in[11:7];
  assign w_rm_rr  = {w_rm, w_rm} >> w_amt;

  always_comb begin
    case (shift_operand_in[6:5])
      2'b00:   w_shf = w_rm << w_amt;
      2'b01:   w_shf = w_rm >> w_amt;
      2'b10:   w_shf = DATA_W'($signed(w_rm) >>> w_amt);
      default: w_shf = w_rm_rr[DATA_W-1:0];
    endcase
  end

  // Loads/stores use the raw 12-bit offset regardless of imm_in.
  always_comb begin
    if (mem_r_en_in || mem_w_en_in) w_val2 = {{(DATA_W-12){1'b0}}, shift_operand_in};
    else if (imm_in)                w_val2 = w_imm_rr[DATA_W-1:0];
    else                            w_val2 = w_shf;
  end

  // Subtraction is op1 + ~val2 + carry-in; the carry out then means "no borrow".
  always_comb begin
    w_b     = w_val2;
    w_ci    = 1'b0;
    w_arith = 1'b0;
    w_res   = '0;
    case (exe_cmd_in)
      4'b0010: begin w_arith = 1'b1; end
      4'b0011: begin w_arith = 1'b1; w_ci = sr_in[1]; end
      4'b0100: begin w_arith = 1'b1; w_b = ~w_val2; w_ci = 1'b1; end
      4'b0101: begin w_arith = 1'b1; w_b = ~w_val2; w_ci = sr_in[1]; end
      default: ;
    endcase
    w_sum = {1'b0, w_op1} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_ci};
    case (exe_cmd_in)
      4'b0001: w_res = w_val2;
      4'b1001: w_res = ~w_val2;
      4'b0110: w_res = w_op1 & w_val2;
      4'b0111: w_res = w_op1 | w_val2;
      4'b1000: w_res = w_op1 ^ w_val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: w_res = w_sum[DATA_W-1:0];
      default: w_res = '0;
    endcase
    w_n = w_res[DATA_W-1];
    w_z = (w_res == '0);
    w_c = w_arith ? w_sum[DATA_W] : sr_in[1];
    w_v = w_arith ? ((w_op1[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_op1[DATA_W-1]))
                  : sr_in[0];
  end

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(DATA_W-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_alu_res  <= '0;
      r_val_rm   <= '0;
      r_dest     <= '0;
    end else begin
      if (s_in) r_status <= {w_n, w_z, w_c, w_v};
      r_wb_en    <= wb_en_in;
      r_mem_r_en <= mem_r_en_in;
      r_mem_w_en <= mem_w_en_in;
      r_alu_res  <= w_res;
      r_val_rm   <= w_rm;
      r_dest     <= dest_in;
    end
  end

  assign status   = r_status;
  assign wb_en    = r_wb_en;
  assign mem_r_en = r_mem_r_en;
  assign mem_w_en = r_mem_w_en;
  assign alu_res  = r_alu_res;
  assign val_rm   = r_val_rm;
  assign dest     = r_dest;

endmodule
